// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Opcodes, FSM state encoding and request bundle sizing.
package alu_op_sequencer_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_SUB  = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_OR   = 3'd3;
    localparam op_t OP_NEG  = 3'd4;
    localparam op_t OP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Packed request {a, b, cin, sel} width for operand width w.
    function automatic int req_w(input int w);
        return 2 * w + 4;
    endfunction

    function automatic logic op_legal(input op_t op);
        return op <= OP_NEG;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU drive and response bundle of the sequencer.
// master = environment side, slave = sequencer side.
interface alu_op_sequencer_if
    import alu_op_sequencer_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [W-1:0]           req_a;
    logic [W-1:0]           req_b;
    logic                   req_cin;
    op_t                    req_sel;

    logic [W-1:0]           alu_a;
    logic [W-1:0]           alu_b;
    logic                   alu_cin;
    op_t                    alu_sel;
    logic [W:0]             alu_out;
    logic                   alu_cout;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [W:0]             rsp_out;
    logic                   rsp_cout;
    logic                   rsp_err;

    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_sel,
        input  req_ready,
        input  alu_a, alu_b, alu_cin, alu_sel,
        output alu_out, alu_cout,
        input  rsp_valid, rsp_out, rsp_cout, rsp_err,
        output rsp_ready,
        input  fifo_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sel,
        output req_ready,
        output alu_a, alu_b, alu_cin, alu_sel,
        input  alu_out, alu_cout,
        output rsp_valid, rsp_out, rsp_cout, rsp_err,
        input  rsp_ready,
        output fifo_count
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through head.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [DW-1:0]          din_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and occupancy from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: queues requests, drives one
// operation at a time and returns results in request order.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);
    localparam int RW = req_w(W);

    logic [RW-1:0] push_data;
    logic [RW-1:0] head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;
    logic          head_cin;
    op_t           head_sel;

    state_e        state_q, state_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic          alu_cin_q, alu_cin_d;
    op_t           alu_sel_q, alu_sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [W:0]    rsp_out_q, rsp_out_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_err_q, rsp_err_d;

    assign push_data = {bus.req_a, bus.req_b, bus.req_cin, bus.req_sel};
    assign push      = bus.req_valid && bus.req_ready;
    assign bus.req_ready = !fifo_full;

    assign head_a   = head[RW-1 -: W];
    assign head_b   = head[W+3 -: W];
    assign head_cin = head[3];
    assign head_sel = head[2:0];

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .DW    (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.fifo_count)
    );

    // Next state: pop in IDLE or on a response handshake, then
    // either issue the head to the ALU or answer it as illegal.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: pop = !fifo_empty;
            EXEC: begin
                rsp_out_d   = bus.alu_out;
                rsp_cout_d  = bus.alu_cout;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (fifo_empty) begin
                        alu_sel_d = OP_IDLE;
                        state_d   = IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            if (op_legal(head_sel)) begin
                alu_a_d   = head_a;
                alu_b_d   = head_b;
                alu_cin_d = head_cin;
                alu_sel_d = head_sel;
                state_d   = EXEC;
            end else begin
                rsp_out_d   = '0;
                rsp_cout_d  = 1'b0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
        end
    end

    // State, ALU drive and response registers; reset aborts all work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_sel_q   <= OP_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the 4-bit ALU datapath (the ALU takes a, b, cin, sel and returns out[4:0] and cout).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered operands and opcode to the ALU one operation at a time, samples the ALU result, and returns it over a valid/ready response handshake.
- Rejects unsupported opcodes without issuing them.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >= 2)
W, 4, operand width (ALU is 4-bit; result width is W+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_a  in  W  operand a
req_b  in  W  operand b
req_cin  in  1  carry-in, forwarded unchanged
req_sel  in  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 negate b; 5-7 illegal
alu_a  out  W  registered operand to ALU
alu_b  out  W  registered operand to ALU
alu_cin  out  1  registered carry-in to ALU
alu_sel  out  3  registered opcode to ALU
alu_out  in  W+1  ALU result (combinational from alu_*)
alu_cout  in  1  ALU carry/borrow (alu_out[W])
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_out  out  W+1  captured result
rsp_cout  out  1  captured carry
rsp_err  out  1  1 = illegal opcode, no ALU issue
fifo_count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (reset=0, async) sets:
  - FIFO empty, fifo_count=0.
  - State IDLE.
  - alu_a=0, alu_b=0, alu_cin=0, alu_sel=3'b111 (idle no-op code).
  - rsp_valid=0, rsp_out=0, rsp_cout=0, rsp_err=0.
- Release of reset is synchronous to clk. Reset during any state aborts the in-flight operation and discards its response and all FIFO contents.
- req_ready = (fifo_count < DEPTH). It is independent of a same-cycle pop, so a push into a full FIFO is never attempted. Push on handshake; pointers wrap mod DEPTH.
- State IDLE:
  - If the FIFO is non-empty at the clock edge, pop the head.
  - Legal opcode: load alu_* from the head and go to EXEC.
  - Illegal opcode (5-7): load rsp_out=0, rsp_cout=0, rsp_err=1, set rsp_valid=1, go to RESP. alu_* are unchanged.
- State EXEC (exactly one cycle):
  - alu_* are stable, so the ALU output settles.
  - At the edge, capture rsp_out=alu_out, rsp_cout=alu_cout, rsp_err=0, set rsp_valid=1, go to RESP.
- State RESP:
  - Hold rsp_* and alu_* stable while rsp_valid && !rsp_ready.
  - On the handshake edge, if the FIFO is non-empty, pop and go directly to EXEC (or stay in RESP with the error response for an illegal head). Otherwise clear rsp_valid and go to IDLE; alu_sel returns to 3'b111.
- Latency:
  - Request accepted at edge T: rsp_valid rises after edge T+2, or T+1 for an illegal opcode.
  - With rsp_ready held high, sustained throughput is one legal op per 2 cycles.
- Ordering: responses are strictly in request order.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- rsp_valid never drops without a handshake, and rsp_* never change while rsp_valid && !rsp_ready.
- Result width: rsp_out is the full (W+1)-bit ALU value, with no truncation or sign interpretation.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_NEG=4, OP_IDLE=3'b111.
  - sequencer state encoding IDLE/EXEC/RESP.
  - request bundle width ({a,b,cin,sel} = 2W+4).
- One sub-module: alu_req_fifo, a synchronous FIFO parameterised by DEPTH and data width, exposing full, empty and count.

Test Plan:
- Add with carry: {a=7, b=9, sel=0}, rsp_ready=1, alu model connected -> rsp_out=5'h10, rsp_cout=1, rsp_err=0, rsp_valid 2 cycles after accept.
- Subtract and negate in order: {3,5,sel=1} then {0,1,sel=4} -> first response rsp_out=5'h1E, rsp_cout=1; second rsp_out=5'h1F; order preserved; alu_sel sequence 1, 4, then 7 in IDLE.
- Illegal opcode: {a=2, b=2, sel=6} -> no EXEC cycle, alu_sel stays 7, response rsp_err=1, rsp_out=0, rsp_valid 1 cycle after accept.
- Backpressure and full FIFO: rsp_ready=0, offer 6 requests back-to-back -> 5 accepted (1 held in RESP, 4 in FIFO), fifo_count=4, req_ready=0. Then rsp_ready=1 -> all 5 responses drain in order and req_ready reasserts after the first pop.
- Response stability: stall rsp_ready=0 for 10 cycles mid-stream -> rsp_out, rsp_cout, rsp_err and alu_* constant, rsp_valid held.
- Reset mid-operation: assert reset in EXEC with 3 requests queued -> immediately rsp_valid=0, fifo_count=0, alu_sel=7. After release, no stale response appears and a new {1,1,sel=0} returns 5'h02.
